// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate-format
// enumerations, the ID/EX register layout and the funct3 -> ALU op helper.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_t     alu_op;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } idex_t;

  // alt selects SUB/SRA (instr[30]); callers mask it where it does not apply.
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: sign-extends the I/S/B/U/J fields
// of an instruction word; IMM_NONE (R-type, illegal) yields zero.
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'h0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decode, load-use / write-back hazard handling and the
// ID/EX register. Define DECODE_WB_BYPASS_EN to bypass same-cycle write-back.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  input  logic        flush,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic        ex_reg_write,
  output logic        ex_is_load,
  output logic        ex_is_store,
  output logic        ex_is_branch,
  output logic        ex_is_jump,
  output logic        ex_illegal
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // if_instr is consumed when if_valid && id_ready; ID/EX is consumed when
  // ex_valid && ex_ready. id_ready never depends on if_valid.

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2, writes_rd;
  imm_fmt_t   imm_fmt;
  alu_op_t    alu_op;
  logic       is_load, is_store, is_branch, is_jump, illegal;
  logic [31:0] imm;
  logic [31:0] rs1_val, rs2_val;
  logic       wb_hit1, wb_hit2, load_use, wb_stall, stall, accept;
  idex_t      idex_d, idex_q;

  assign opcode = if_instr[6:0];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  always_comb begin
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    imm_fmt   = IMM_NONE;
    alu_op    = ALU_ADD;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI:    begin use_rs1 = 1'b0; writes_rd = 1'b1; imm_fmt = IMM_U; alu_op = ALU_PASS_B; end
      OPC_AUIPC:  begin use_rs1 = 1'b0; writes_rd = 1'b1; imm_fmt = IMM_U; end
      OPC_JAL:    begin use_rs1 = 1'b0; writes_rd = 1'b1; imm_fmt = IMM_J; is_jump = 1'b1; end
      OPC_JALR:   begin writes_rd = 1'b1; imm_fmt = IMM_I; is_jump = 1'b1; end
      OPC_BRANCH: begin use_rs2 = 1'b1; imm_fmt = IMM_B; alu_op = ALU_SUB; is_branch = 1'b1; end
      OPC_LOAD:   begin writes_rd = 1'b1; imm_fmt = IMM_I; is_load = 1'b1; end
      OPC_STORE:  begin use_rs2 = 1'b1; imm_fmt = IMM_S; is_store = 1'b1; end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        imm_fmt   = IMM_I;
        // addi has no subtract form; only the right shifts use instr[30].
        alu_op    = alu_from_funct3(if_instr[14:12], (if_instr[14:12] == 3'b101) && if_instr[30]);
      end
      OPC_OP: begin
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
        alu_op    = alu_from_funct3(if_instr[14:12], if_instr[30]);
      end
      default:    illegal = 1'b1;
    endcase
  end

  imm_gen u_imm_gen (
    .instr (if_instr),
    .fmt   (imm_fmt),
    .imm   (imm)
  );

  assign wb_hit1 = wb_we && (wb_rd != 5'd0) && (wb_rd == rs1);
  assign wb_hit2 = wb_we && (wb_rd != 5'd0) && (wb_rd == rs2);

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_val  = wb_hit1 ? wb_data : rf_data1;
  assign rs2_val  = wb_hit2 ? wb_data : rf_data2;
  assign wb_stall = 1'b0;
`else
  // Without the bypass, wait until the register file holds the written value.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign rs1_val  = rf_data1;
  assign rs2_val  = rf_data2;
  assign wb_stall = (use_rs1 && wb_hit1) || (use_rs2 && wb_hit2);
`endif

  assign load_use = idex_q.valid && idex_q.is_load && (idex_q.rd != 5'd0) &&
                    ((use_rs1 && (rs1 == idex_q.rd)) || (use_rs2 && (rs2 == idex_q.rd)));
  assign stall    = load_use || wb_stall;
  assign id_ready = (!idex_q.valid || ex_ready) && !stall;
  assign accept   = if_valid && id_ready;

  always_comb begin
    idex_d           = '0;
    idex_d.valid     = 1'b1;
    idex_d.pc        = if_pc;
    idex_d.rs1_val   = rs1_val;
    idex_d.rs2_val   = rs2_val;
    idex_d.imm       = imm;
    idex_d.rd        = (writes_rd && !illegal) ? rd : 5'd0;
    idex_d.alu_op    = alu_op;
    idex_d.reg_write = writes_rd && (rd != 5'd0);
    idex_d.is_load   = is_load;
    idex_d.is_store  = is_store;
    idex_d.is_branch = is_branch;
    idex_d.is_jump   = is_jump;
    idex_d.illegal   = illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else if (flush) begin
      idex_q.valid <= 1'b0;
    end else if (accept) begin
      idex_q <= idex_d;
    end else if (ex_ready) begin
      idex_q.valid <= 1'b0;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_pc        = idex_q.pc;
  assign ex_rs1_val   = idex_q.rs1_val;
  assign ex_rs2_val   = idex_q.rs2_val;
  assign ex_imm       = idex_q.imm;
  assign ex_rd        = idex_q.rd;
  assign ex_alu_op    = idex_q.alu_op;
  assign ex_reg_write = idex_q.reg_write;
  assign ex_is_load   = idex_q.is_load;
  assign ex_is_store  = idex_q.is_store;
  assign ex_is_branch = idex_q.is_branch;
  assign ex_is_jump   = idex_q.is_jump;
  assign ex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded RV32I vectors with hand-computed
// expectations; honours DECODE_WB_BYPASS_EN for the write-back cases.
module tb_decode_stage;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_PASS_B = 4'd10;

  localparam logic [31:0] I_ADDI_M1   = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] I_BEQ_M4    = 32'hFE208EE3; // beq x1,x2,-4
  localparam logic [31:0] I_JAL_2048  = 32'h001000EF; // jal x1,+2048
  localparam logic [31:0] I_SW        = 32'h00322623; // sw x3,12(x4)
  localparam logic [31:0] I_LW_X6     = 32'h00012303; // lw x6,0(x2)
  localparam logic [31:0] I_LW_X0     = 32'h00012003; // lw x0,0(x2)
  localparam logic [31:0] I_ADD_761   = 32'h001303B3; // add x7,x6,x1
  localparam logic [31:0] I_ADD_712   = 32'h002083B3; // add x7,x1,x2
  localparam logic [31:0] I_ADD_311   = 32'h001081B3; // add x3,x1,x1
  localparam logic [31:0] I_SUB_312   = 32'h402081B3; // sub x3,x1,x2
  localparam logic [31:0] I_LUI       = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] I_ILLEGAL   = 32'h0000007F;

  logic        clk, rst_n;
  logic        if_valid, flush, ex_ready, wb_we;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        id_ready;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_data1, rf_data2;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_illegal;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  // Register file model: xN reads as 0x10 + N.
  assign rf_data1 = 32'h10 + {27'h0, rf_rs1};
  assign rf_data2 = 32'h10 + {27'h0, rf_rs2};

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_illegal(ex_illegal)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Driver: present one instruction and return #1 after the edge that took it.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    int n;
    if_instr = instr;
    if_pc    = pc;
    if_valid = 1'b1;
    n = 0;
    #1;
    while (!id_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!id_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
    flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    #12;
    check("rst_ex_valid", {31'h0, ex_valid}, 32'd0);
    check("rst_ex_pc", ex_pc, 32'h0);
    check("rst_ex_imm", ex_imm, 32'h0);
    check("rst_ex_flags", {26'h0, ex_reg_write, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_illegal}, 32'h0);
    check("rst_id_ready", {31'h0, id_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // addi x5,x0,-1
    send(I_ADDI_M1, 32'h100);
    check("addi_valid", {31'h0, ex_valid}, 32'd1);
    check("addi_pc", ex_pc, 32'h100);
    check("addi_imm", ex_imm, 32'hFFFFFFFF);
    check("addi_rd", {27'h0, ex_rd}, 32'd5);
    check("addi_alu", {28'h0, ex_alu_op}, {28'h0, A_ADD});
    check("addi_wr", {31'h0, ex_reg_write}, 32'd1);

    // Immediate formats
    send(I_BEQ_M4, 32'h104);
    check("beq_imm", ex_imm, 32'hFFFFFFFC);
    check("beq_branch", {31'h0, ex_is_branch}, 32'd1);
    check("beq_wr", {31'h0, ex_reg_write}, 32'd0);
    send(I_JAL_2048, 32'h108);
    check("jal_imm", ex_imm, 32'h00000800);
    check("jal_jump", {31'h0, ex_is_jump}, 32'd1);
    send(I_SW, 32'h10C);
    check("sw_imm", ex_imm, 32'd12);
    check("sw_store", {31'h0, ex_is_store}, 32'd1);
    check("sw_rs2", ex_rs2_val, 32'h13);

    // Load-use: exactly one bubble
    send(I_LW_X6, 32'h110);
    check("lw_load", {31'h0, ex_is_load}, 32'd1);
    if_instr = I_ADD_761; if_pc = 32'h114; if_valid = 1'b1;
    #1;
    check("lu_stall_ready", {31'h0, id_ready}, 32'd0);
    check("lu_rf_rs1", {27'h0, rf_rs1}, 32'd6);
    check("lu_rf_rs2", {27'h0, rf_rs2}, 32'd1);
    @(posedge clk); #1;
    check("lu_bubble", {31'h0, ex_valid}, 32'd0);
    check("lu_ready_after", {31'h0, id_ready}, 32'd1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    check("lu_add_valid", {31'h0, ex_valid}, 32'd1);
    check("lu_add_pc", ex_pc, 32'h114);
    check("lu_add_rs1", ex_rs1_val, 32'h16);

    // No dependency, then lw x0: no stall
    send(I_LW_X6, 32'h118);
    if_instr = I_ADD_712; if_pc = 32'h11C; if_valid = 1'b1;
    #1;
    check("nodep_ready", {31'h0, id_ready}, 32'd1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    check("nodep_pc", ex_pc, 32'h11C);
    check("nodep_vals", {ex_rs1_val[15:0], ex_rs2_val[15:0]}, 32'h00110012);
    send(I_LW_X0, 32'h120);
    check("lwx0_rd", {27'h0, ex_rd}, 32'd0);
    if_instr = I_ADD_761; if_pc = 32'h124; if_valid = 1'b1;
    #1;
    check("lwx0_ready", {31'h0, id_ready}, 32'd1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    check("lwx0_pc", ex_pc, 32'h124);

    // Same-cycle write-back of x1
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h22;
    if_instr = I_ADD_311; if_pc = 32'h128; if_valid = 1'b1;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    check("byp_ready", {31'h0, id_ready}, 32'd1);
    @(posedge clk); #1;
    if_valid = 1'b0; wb_we = 1'b0;
    check("byp_rs1", ex_rs1_val, 32'h22);
    check("byp_rs2", ex_rs2_val, 32'h22);
`else
    check("wbst_ready0", {31'h0, id_ready}, 32'd0);
    @(posedge clk); #1;
    check("wbst_ready1", {31'h0, id_ready}, 32'd0);
    check("wbst_bubble", {31'h0, ex_valid}, 32'd0);
    wb_we = 1'b0;
    #1;
    check("wbst_release", {31'h0, id_ready}, 32'd1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    check("wbst_rs1", ex_rs1_val, 32'h11);
    check("wbst_rs2", ex_rs2_val, 32'h11);
`endif
    check("wb_pc", ex_pc, 32'h128);

    // Backpressure: 3 held cycles
    send(I_SUB_312, 32'h300);
    ex_ready = 1'b0;
    if_instr = I_LUI; if_pc = 32'h304; if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", {31'h0, id_ready}, 32'd0);
      @(posedge clk); #1;
      check("bp_pc", ex_pc, 32'h300);
      check("bp_alu", {28'h0, ex_alu_op}, {28'h0, A_SUB});
      check("bp_valid", {31'h0, ex_valid}, 32'd1);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_release", {31'h0, id_ready}, 32'd1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    check("lui_imm", ex_imm, 32'h12345000);
    check("lui_alu", {28'h0, ex_alu_op}, {28'h0, A_PASS_B});
    check("lui_pc", ex_pc, 32'h304);

    // Flush while accepting
    if_instr = I_ADDI_M1; if_pc = 32'h400; if_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_ready", {31'h0, id_ready}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    check("flush_valid", {31'h0, ex_valid}, 32'd0);

    // Illegal opcode
    send(I_ILLEGAL, 32'h404);
    check("ill_flag", {31'h0, ex_illegal}, 32'd1);
    check("ill_wr", {31'h0, ex_reg_write}, 32'd0);
    check("ill_class", {28'h0, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump}, 32'd0);

    // Back-to-back throughput with expected-PC queue
    for (int i = 0; i < 3; i++) begin
      if_instr = I_ADDI_M1; if_pc = 32'h500 + 32'(4 * i); if_valid = 1'b1;
      exp_q.push_back(if_pc);
      @(posedge clk); #1;
      check("tp_valid", {31'h0, ex_valid}, 32'd1);
      check("tp_pc", ex_pc, exp_q.pop_front());
    end
    if_valid = 1'b0;

    // Asynchronous reset during a hold
    send(I_ADDI_M1, 32'h600);
    ex_ready = 1'b0;
    @(posedge clk); #1;
    check("hold_valid", {31'h0, ex_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, ex_valid}, 32'd0);
    check("arst_pc", ex_pc, 32'h0);
    check("arst_ready", {31'h0, id_ready}, 32'd1);
    #3 rst_n = 1'b1;
    ex_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction decode stage: accepts fetched instructions over a valid/ready handshake, drives the register-file read addresses, decodes the instruction and generates its immediate, and registers the result into the ID/EX pipeline register. Sits between fetch and execute and directly consumes the register file's combinational read ports. It also detects load-use hazards and bypasses a same-cycle register write-back, which the register file does not forward itself.

## Interface
- No parameters; widths are fixed by RV32I (XLEN 32, 5-bit register indices).
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- id_ready  out  1  stage accepts if_instr this cycle (combinational)
- flush  in  1  kill the instruction held in the stage and any instruction accepted this cycle
- rf_rs1, rf_rs2  out  5  register-file read addresses (combinational: if_instr[19:15], [24:20])
- rf_data1, rf_data2  in  32  register-file read data (combinational)
- wb_we, wb_rd, wb_data  in  1/5/32  write-back port as presented to the register file this cycle
- ex_ready  in  1  execute accepts the ID/EX contents
- ex_valid  out  1  ID/EX holds a live instruction
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  32 each
- ex_rd  out  5; ex_alu_op  out  4 (enumeration in package)
- ex_reg_write, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_illegal  out  1 each

## Operation
- Decode covers opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode sets ex_illegal=1, ex_reg_write=0, and all other class flags 0.
- Immediate formats I/S/B/U/J are sign-extended to 32 bits. B and J immediates have bit0=0. R-type gives ex_imm=0.
- Source-use rules:
  - rs1 is used by every opcode except LUI, AUIPC, and JAL.
  - rs2 is used by BRANCH, STORE, and OP.
  - An index of x0 never creates a hazard or a bypass.
- ex_reg_write=1 for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP when rd!=0; otherwise 0.
- Write-back bypass: if wb_we && wb_rd!=0 && wb_rd==rs1, the stage latches wb_data instead of rf_data1. The same rule applies to rs2.
- Load-use hazard:
  - Condition: ex_valid && ex_is_load && ex_rd!=0 && a used source equals ex_rd.
  - Effect: stall=1, id_ready=0, and if_instr is not consumed.
  - If ex_ready=1, ID/EX loads a bubble (ex_valid<=0).
  - Forwarding from MEM/WB after the bubble is execute's responsibility.
- id_ready = (!ex_valid || ex_ready) && !stall.
- ID/EX update priority per edge:
  - flush → ex_valid<=0.
  - else if_valid && id_ready → load the decoded instruction, ex_valid<=1.
  - else ex_ready → ex_valid<=0.
  - else hold all fields.
- Flush and accept in the same cycle: the accepted instruction is discarded. id_ready is not gated by flush.

## Timing
- Latency: 1 cycle from acceptance to ex_valid.
- Throughput: 1 instruction/cycle with no hazard.
- A load-use stall costs exactly one bubble when ex_ready=1.
- While ex_ready=0, all ex_* outputs are held stable and id_ready=0.
- Reset (asynchronous assert, synchronous-safe deassert): every ex_* output is 0, and ex_valid=0. id_ready is therefore 1 out of reset.
- Reset asserted mid-stall or mid-hold clears the ID/EX contents immediately. No instruction survives reset.
- rf_rs1/rf_rs2 follow if_instr combinationally, including while stalled.

## Configuration
- DECODE_WB_BYPASS_EN defined: write-back bypass as above, with no stall for a write-back match.
- Macro undefined: no bypass mux. A used source matching wb_rd (wb_we=1, wb_rd!=0) raises stall; this is combined by OR with the load-use stall. ID/EX behaves as for load-use, and the instruction is accepted on the first cycle with no match.

## Structure
- A shared package holds:
  - opcode constants (OPC_LUI … OPC_OP);
  - the alu_op_t 4-bit enumeration (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B);
  - the imm_fmt_t enumeration (I, S, B, U, J, NONE).
- Sub-module imm_gen (combinational: instr and format → 32-bit immediate).
- Decode logic, hazard logic, bypass logic, and the ID/EX register live in decode_stage.

## Test plan
- Reset with if_valid=0: all ex_* outputs are 0 and id_ready=1. Then addi x5,x0,-1 (0xFFF00293) is accepted → next cycle ex_valid=1, ex_imm=0xFFFFFFFF, ex_rd=5, ex_alu_op=ADD, ex_reg_write=1.
- Immediates:
  - beq x1,x2,-4 → ex_imm=0xFFFFFFFC, ex_is_branch=1, ex_reg_write=0.
  - jal x1,+2048 → ex_imm=0x00000800.
  - sw x3,12(x4) → ex_imm=12, ex_is_store=1.
- Load-use: lw x6,0(x2) followed by add x7,x6,x1 with ex_ready=1 → one cycle of id_ready=0 and ex_valid=0 bubble, then add is accepted. Using add x7,x1,x2 instead gives no stall. Using lw x0 gives no stall.
- Bypass, macro defined: rf_data1=0x11, wb_we=1, wb_rd=1, wb_data=0x22, add x3,x1,x1 → ex_rs1_val=ex_rs2_val=0x22. Macro undefined: id_ready=0 until wb_we drops, then 0x11 values are latched from the register file.
- Backpressure and flush: ex_ready=0 for 3 cycles → outputs stable and id_ready=0. flush while accepting → ex_valid=0 next cycle.
- Illegal opcode 0x0000007F → ex_illegal=1 and ex_reg_write=0. Asserting rst_n=0 mid-hold clears ex_valid without waiting for a clock edge.
